kgp_dmem_io: RTL and testbench
==============================

Name: kgp_dmem_io

Overview:
Data-memory and memory-mapped I/O controller directly downstream of the single-cycle CPU core. It consumes the core's data address, store data and byte-write enables, and produces the load-data word the core writes back. Data-region accesses go to the data BRAM. A small MMIO window provides:
- a character output FIFO with a valid/ready drain port,
- a status register,
- a free-running cycle counter that freezes when the core halts.

Parameters:
DMEM_AW, 10, data BRAM word-address width (4 KiB region at 0x0000_0000)
FIFO_DEPTH, 8, output FIFO entries (power of two, >=2)
MMIO_BASE, 32'hFFFF_FF00, base byte address of the MMIO window

Ports:
clk  in  1  system clock, all state on rising edge
start  in  1  synchronous active-low reset (start==0 at a rising edge resets the block)
cpu_da  in  32  data byte address from core
cpu_wdata  in  32  store data from core
cpu_wea  in  4  byte write enables from core (4'b1111 on store, else 0)
cpu_stop  in  1  core halt indication
cpu_rdata  out  32  load data to core (core's doutd)
mem_addr  out  DMEM_AW  BRAM word address
mem_din  out  32  BRAM write data
mem_wea  out  4  BRAM byte write enables
mem_dout  in  32  BRAM read data
out_data  out  8  FIFO head byte
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head byte this cycle
halted  out  1  sticky halt flag

Behaviour:
- Decode is combinational on cpu_da.
  - DMEM: cpu_da[31:DMEM_AW+2]==0.
  - MMIO: cpu_da[31:4]==MMIO_BASE[31:4].
  - Else UNMAPPED.
- DMEM path:
  - mem_addr = cpu_da[DMEM_AW+1:2].
  - mem_din = cpu_wdata.
  - mem_wea = cpu_wea only when decode is DMEM, else 4'b0000.
  - mem_dout is passed to cpu_rdata unregistered; BRAM read timing is owned by the core.
- MMIO registers, selected by offset cpu_da[3:0]:
  - 0x0 TXDATA, write: push cpu_wdata[7:0]; read returns 0.
  - 0x4 STATUS, read: {28'b0, ovf, full, empty, halted}. A write with cpu_wdata[3]==1 clears ovf. Other bits are read-only.
  - 0x8 CYCLES, read-only: 32-bit counter.
  - 0xC ERRCNT, read-only: 32-bit count of writes to UNMAPPED addresses. Saturates at 32'hFFFF_FFFF.
- Reads of UNMAPPED addresses and unused MMIO offsets return 32'hDEAD_BEEF.
- A write is any cycle with cpu_wea != 0. MMIO/ERRCNT write effects commit at the rising edge.
- FIFO:
  - Push when a TXDATA write occurs and (!full || pop). Push+pop in the same cycle when full is accepted and count stays unchanged.
  - Push while full with no pop is dropped and sets sticky ovf.
  - Pop when out_valid && out_ready. out_data = head entry (first-word fall-through).
  - Pointers wrap modulo FIFO_DEPTH. Count has range 0..FIFO_DEPTH.
  - Push into an empty FIFO: out_valid rises the following cycle.
- CYCLES:
  - Increments by 1 every cycle while !halted; wraps 32'hFFFF_FFFF -> 0.
  - Freezes on the cycle after halted is set; the value read stays constant thereafter.
- halted:
  - Set at the rising edge where cpu_stop==1; held until reset.
  - FIFO continues draining after halt.
  - MMIO/DMEM accesses are still honoured after halt; the core is expected to be idle.
- Reset (start==0), synchronous, regardless of activity in the same cycle:
  - FIFO empty (out_valid=0, out_data=0), ovf=0, halted=0, CYCLES=0, ERRCNT=0.
  - A push or pop presented in the reset cycle is discarded.
  - Combinational outputs follow the inputs during reset, except that mem_wea is forced to 0 while start==0.

Decomposition:
- Shared package kgp_mmio_pkg holds:
  - MMIO offset constants (OFF_TXDATA, OFF_STATUS, OFF_CYCLES, OFF_ERRCNT),
  - STATUS bit positions,
  - the UNMAPPED_RDATA constant 32'hDEAD_BEEF,
  - a region-decode enum {REG_DMEM, REG_MMIO, REG_UNMAPPED}.
- One sub-module, kgp_sync_fifo: parameterised width/depth, FWFT, synchronous active-low reset, exposing full/empty/count.

Test Plan:
- Reset then store 0x1234_5678 to 0x0000_0010 -> mem_addr=4, mem_wea=4'hF, mem_din=0x1234_5678; load from the same address returns the mem_dout model value on cpu_rdata.
- Write 'A','B','C' to 0xFFFF_FF00 with out_ready=0 -> STATUS reads 0x0; then raise out_ready -> out_data 0x41, 0x42, 0x43 on consecutive cycles, then out_valid=0 and STATUS=0x2.
- Nine TXDATA writes with out_ready=0 -> ninth dropped, STATUS=0xC (ovf|full); write 0x8 to STATUS -> STATUS=0x4; drain yields exactly 8 bytes in order.
- Fill FIFO, then TXDATA write with out_ready=1 same cycle -> byte accepted, count stays 8, ovf stays 0.
- Read CYCLES at cycles N and N+5 -> difference 5; assert cpu_stop -> halted=1, CYCLES constant over 20 cycles; STATUS bit0=1.
- Store to 0x8000_0000 twice -> mem_wea stays 0, ERRCNT=2, load from 0x8000_0000 returns 0xDEAD_BEEF; pull start low mid-FIFO-drain -> next cycle out_valid=0, ERRCNT=0, CYCLES=0.

Source files
------------

// File: rtl/kgp_mmio_pkg.sv
// Shared constants and region decode for the kgp data-memory / MMIO controller.
package kgp_mmio_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CYCLES = 4'h8;
  localparam logic [3:0] OFF_ERRCNT = 4'hC;

  localparam int unsigned ST_HALTED = 0;
  localparam int unsigned ST_EMPTY  = 1;
  localparam int unsigned ST_FULL   = 2;
  localparam int unsigned ST_OVF    = 3;

  localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    REG_DMEM,
    REG_MMIO,
    REG_UNMAPPED
  } region_e;

  // DMEM occupies [0, 4 << aw); the MMIO window is the 16-byte block at base.
  function automatic region_e decode_region(input logic [31:0] addr, input int unsigned aw,
                                            input logic [31:0] base);
    if ((addr >> (aw + 32'd2)) == 32'd0) return REG_DMEM;
    if (addr[31:4] == base[31:4]) return REG_MMIO;
    return REG_UNMAPPED;
  endfunction

endpackage

// File: rtl/kgp_sync_fifo.sv
// First-word fall-through synchronous FIFO; head reads as zero while empty.
module kgp_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pop frees a slot in the same cycle, so push-while-full is legal alongside it.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) count_d = count_q + (AW + 1)'(1);
    if (!do_push && do_pop) count_d = count_q - (AW + 1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/kgp_dmem_io.sv
// Data BRAM steering plus MMIO window (char FIFO, status, cycle counter, error
// counter) sitting on the core's data port.
module kgp_dmem_io
  import kgp_mmio_pkg::*;
#(
  parameter int unsigned DMEM_AW    = 10,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic               clk,
  input  logic               start,
  input  logic [31:0]        cpu_da,
  input  logic [31:0]        cpu_wdata,
  input  logic [3:0]         cpu_wea,
  input  logic               cpu_stop,
  output logic [31:0]        cpu_rdata,
  output logic [DMEM_AW-1:0] mem_addr,
  output logic [31:0]        mem_din,
  output logic [3:0]         mem_wea,
  input  logic [31:0]        mem_dout,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               halted
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  region_e       region;
  logic [3:0]    offset;
  logic          wr_any, tx_wr, st_wr;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          unused_fifo_count;
  logic          ovf_q, ovf_d;
  logic          halted_q, halted_d;
  logic [31:0]   cycles_q, cycles_d;
  logic [31:0]   errcnt_q, errcnt_d;
  logic [31:0]   status;

  assign region = decode_region(cpu_da, DMEM_AW, MMIO_BASE);
  assign offset = cpu_da[3:0];
  assign wr_any = |cpu_wea;
  assign tx_wr  = wr_any && (region == REG_MMIO) && (offset == OFF_TXDATA);
  assign st_wr  = wr_any && (region == REG_MMIO) && (offset == OFF_STATUS);

  assign mem_addr = cpu_da[DMEM_AW+1:2];
  assign mem_din  = cpu_wdata;
  assign mem_wea  = (start && region == REG_DMEM) ? cpu_wea : 4'b0000;

  assign fifo_pop  = out_ready && !fifo_empty;
  assign fifo_push = tx_wr && (!fifo_full || fifo_pop);

  kgp_sync_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (start),
    .push_i  (fifo_push),
    .wdata_i (cpu_wdata[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign unused_fifo_count = ^fifo_count;

  assign out_data  = fifo_head;
  assign out_valid = !fifo_empty;
  assign halted    = halted_q;

  always_comb begin
    halted_d = halted_q | cpu_stop;
    // Counter still advances on the edge that sets halted, then holds.
    cycles_d = halted_q ? cycles_q : cycles_q + 32'd1;
    ovf_d    = ovf_q;
    if (st_wr && cpu_wdata[ST_OVF]) ovf_d = 1'b0;
    if (tx_wr && fifo_full && !fifo_pop) ovf_d = 1'b1;
    errcnt_d = errcnt_q;
    if (wr_any && region == REG_UNMAPPED && errcnt_q != 32'hFFFF_FFFF) begin
      errcnt_d = errcnt_q + 32'd1;
    end
  end

  always_comb begin
    status            = '0;
    status[ST_HALTED] = halted_q;
    status[ST_EMPTY]  = fifo_empty;
    status[ST_FULL]   = fifo_full;
    status[ST_OVF]    = ovf_q;
    cpu_rdata         = UNMAPPED_RDATA;
    if (region == REG_DMEM) begin
      cpu_rdata = mem_dout;
    end else if (region == REG_MMIO) begin
      case (offset)
        OFF_TXDATA: cpu_rdata = '0;
        OFF_STATUS: cpu_rdata = status;
        OFF_CYCLES: cpu_rdata = cycles_q;
        OFF_ERRCNT: cpu_rdata = errcnt_q;
        default:    cpu_rdata = UNMAPPED_RDATA;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!start) begin
      ovf_q    <= 1'b0;
      halted_q <= 1'b0;
      cycles_q <= '0;
      errcnt_q <= '0;
    end else begin
      ovf_q    <= ovf_d;
      halted_q <= halted_d;
      cycles_q <= cycles_d;
      errcnt_q <= errcnt_d;
    end
  end

endmodule

// File: tb/tb_kgp_dmem_io.sv
// Directed plus randomized bench for kgp_dmem_io against a queue-based model.
module tb_kgp_dmem_io;

  localparam int unsigned Depth = 8;

  logic        clk;
  logic        start;
  logic [31:0] cpu_da, cpu_wdata, cpu_rdata, mem_din, mem_dout;
  logic [3:0]  cpu_wea, mem_wea;
  logic        cpu_stop, out_valid, out_ready, halted;
  logic [9:0]  mem_addr;
  logic [7:0]  out_data;

  logic [31:0] bram [1024];
  assign mem_dout = bram[mem_addr];

  kgp_dmem_io #(
    .DMEM_AW    (10),
    .FIFO_DEPTH (Depth),
    .MMIO_BASE  (32'hFFFF_FF00)
  ) dut (
    .clk       (clk),
    .start     (start),
    .cpu_da    (cpu_da),
    .cpu_wdata (cpu_wdata),
    .cpu_wea   (cpu_wea),
    .cpu_stop  (cpu_stop),
    .cpu_rdata (cpu_rdata),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_wea   (mem_wea),
    .mem_dout  (mem_dout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  logic tb_ready, tb_stop;

  // Reference state
  logic [7:0]  m_q[$];
  logic        m_ovf, m_halted, m_ok;
  logic [31:0] m_cycles, m_errcnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_dmem(input logic [31:0] da);
    return da < 32'h0000_1000;
  endfunction

  function automatic logic is_mmio(input logic [31:0] da);
    return (da & 32'hFFFF_FFF0) == 32'hFFFF_FF00;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] da);
    logic [3:0] st;
    if (is_dmem(da)) return bram[da[11:2]];
    if (!is_mmio(da)) return 32'hDEAD_BEEF;
    st = {m_ovf, m_q.size() == Depth, m_q.size() == 0, m_halted};
    case (da & 32'hF)
      32'h0:   return 32'h0;
      32'h4:   return {28'd0, st};
      32'h8:   return m_cycles;
      32'hC:   return m_errcnt;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // One clock: drive, check combinational view against the model, advance model.
  task automatic cycle(input logic [31:0] da, input logic [31:0] wd, input logic [3:0] we,
                       output logic [31:0] rd);
    logic dm, mm;
    cpu_da    = da;
    cpu_wdata = wd;
    cpu_wea   = we;
    cpu_stop  = tb_stop;
    out_ready = tb_ready;
    #2;
    rd = cpu_rdata;
    dm = is_dmem(da);
    mm = is_mmio(da);
    check_eq("mem_wea", {28'd0, mem_wea}, (start && dm) ? {28'd0, we} : 32'd0);
    check_eq("mem_addr", {22'd0, mem_addr}, {22'd0, da[11:2]});
    check_eq("mem_din", mem_din, wd);
    if (m_ok) begin
      check_eq("rdata", rd, exp_rdata(da));
      check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
      if (m_q.size() != 0) check_eq("out_data", {24'd0, out_data}, {24'd0, m_q[0]});
      else check_eq("out_data_empty", {24'd0, out_data}, 32'd0);
      check_eq("halted", {31'd0, halted}, {31'd0, m_halted});
    end
    @(posedge clk);
    if (!start) begin
      m_q.delete();
      m_ovf    = 1'b0;
      m_halted = 1'b0;
      m_cycles = 32'd0;
      m_errcnt = 32'd0;
      m_ok     = 1'b1;
    end else begin
      if (tb_ready && m_q.size() != 0) void'(m_q.pop_front());
      if (we != 4'd0 && mm && da[3:0] == 4'h0) begin
        if (m_q.size() < Depth) m_q.push_back(wd[7:0]);
        else m_ovf = 1'b1;
      end
      if (we != 4'd0 && mm && da[3:0] == 4'h4 && wd[3]) m_ovf = 1'b0;
      if (!m_halted) m_cycles = m_cycles + 32'd1;
      if (tb_stop) m_halted = 1'b1;
      if (we != 4'd0 && !dm && !mm && m_errcnt != 32'hFFFF_FFFF) m_errcnt = m_errcnt + 32'd1;
      if (dm) begin
        for (int b = 0; b < 4; b++) begin
          if (we[b]) bram[da[11:2]][8*b +: 8] = wd[8*b +: 8];
        end
      end
    end
    #1;
  endtask

  task automatic wr(input logic [31:0] da, input logic [31:0] wd);
    logic [31:0] r;
    cycle(da, wd, 4'hF, r);
  endtask

  task automatic rd(input logic [31:0] da, output logic [31:0] r);
    cycle(da, 32'd0, 4'h0, r);
  endtask

  task automatic idle(input int n);
    logic [31:0] r;
    for (int i = 0; i < n; i++) cycle(32'h0, 32'h0, 4'h0, r);
  endtask

  initial begin
    logic [31:0] r, c0, c1, c2, c3, rnd, da;
    int sel;
    checks = 0;
    errors = 0;
    m_ok = 1'b0;
    for (int i = 0; i < 1024; i++) bram[i] = $urandom;
    start = 1'b0; tb_ready = 1'b0; tb_stop = 1'b0;
    cpu_da = '0; cpu_wdata = '0; cpu_wea = '0; cpu_stop = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    idle(2);
    start = 1'b1;

    // DMEM store/load
    wr(32'h0000_0010, 32'h1234_5678);
    rd(32'h0000_0010, r);
    check_eq("dmem_load", r, 32'h1234_5678);

    // Three characters, then drain
    wr(32'hFFFF_FF00, 32'h41);
    wr(32'hFFFF_FF00, 32'h42);
    wr(32'hFFFF_FF00, 32'h43);
    rd(32'hFFFF_FF04, r);
    check_eq("status_abc", r, 32'h0);
    tb_ready = 1'b1;
    idle(3);
    rd(32'hFFFF_FF04, r);
    check_eq("status_drained", r, 32'h2);

    // Overflow and clear
    tb_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(32'hFFFF_FF00, 32'h30 + i);
    rd(32'hFFFF_FF04, r);
    check_eq("status_ovf", r, 32'hC);
    wr(32'hFFFF_FF04, 32'h8);
    rd(32'hFFFF_FF04, r);
    check_eq("status_ovf_clr", r, 32'h4);
    tb_ready = 1'b1;
    idle(8);
    rd(32'hFFFF_FF04, r);
    check_eq("status_after8", r, 32'h2);

    // Push+pop while full
    tb_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(32'hFFFF_FF00, 32'h61 + i);
    tb_ready = 1'b1;
    wr(32'hFFFF_FF00, 32'h5A);
    tb_ready = 1'b0;
    rd(32'hFFFF_FF04, r);
    check_eq("status_full_pp", r, 32'h4);
    tb_ready = 1'b1;
    idle(8);

    // Cycle counter and halt
    rd(32'hFFFF_FF08, c0);
    idle(4);
    rd(32'hFFFF_FF08, c1);
    check_eq("cycles_delta", c1 - c0, 32'd5);
    tb_stop = 1'b1;
    idle(1);
    tb_stop = 1'b0;
    rd(32'hFFFF_FF04, r);
    check_eq("status_halted", {31'd0, r[0]}, 32'd1);
    rd(32'hFFFF_FF08, c2);
    idle(20);
    rd(32'hFFFF_FF08, c3);
    check_eq("cycles_frozen", c3, c2);

    // Unmapped accesses
    wr(32'h8000_0000, 32'hAAAA_5555);
    wr(32'h8000_0000, 32'h5555_AAAA);
    rd(32'hFFFF_FF0C, r);
    check_eq("errcnt2", r, 32'd2);
    rd(32'h8000_0000, r);
    check_eq("unmapped_rd", r, 32'hDEAD_BEEF);
    rd(32'hFFFF_FF01, r);
    check_eq("bad_offset_rd", r, 32'hDEAD_BEEF);

    // Reset mid-drain, with a push presented in the reset cycle
    tb_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(32'hFFFF_FF00, 32'h70 + i);
    tb_ready = 1'b1;
    idle(1);
    start = 1'b0;
    wr(32'hFFFF_FF00, 32'h7F);
    start = 1'b1;
    rd(32'hFFFF_FF08, r);
    check_eq("cycles_after_rst", r, 32'd0);
    check_eq("valid_after_rst", {31'd0, out_valid}, 32'd0);
    rd(32'hFFFF_FF0C, r);
    check_eq("errcnt_after_rst", r, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 8);
      rnd = $urandom;
      case (sel)
        0:       da = rnd & 32'h0000_0FFC;
        1, 7, 8: da = 32'hFFFF_FF00;
        2:       da = 32'hFFFF_FF04;
        3:       da = 32'hFFFF_FF08;
        4:       da = 32'hFFFF_FF0C;
        5:       da = 32'hFFFF_FF00 | (rnd & 32'h0000_000F);
        default: da = (rnd & 32'h7FFF_FFFF) | 32'h0000_1000;
      endcase
      tb_ready = ($urandom_range(0, 1) == 0);
      tb_stop  = ($urandom_range(0, 199) == 0);
      start    = ($urandom_range(0, 99) != 0);
      cycle(da, $urandom, ($urandom_range(0, 2) == 0) ? 4'hF : 4'h0, r);
    end
    start = 1'b1;
    tb_stop = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
